// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RISC-V pipeline: boot sequencing,
// load-use / EX-redirect / memory-wait hazards, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;

  state_t     state, state_nxt;
  logic [3:0] boot_cnt, boot_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use;
  logic       run_eval;
  logic       flush_evt;
  logic       stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // x0 is never a real producer, so it can never create a load-use hazard
  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    wait_cnt_nxt = wait_cnt;
    run_eval     = 1'b0;
    flush_evt    = 1'b0;
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_en_o    = 1'b0;
    idex_flush_o = 1'b0;
    exmem_en_o   = 1'b0;
    memwb_en_o   = 1'b0;

    case (state)
      ST_BOOT: begin
        ifid_flush_o = 1'b1;
        idex_en_o    = 1'b1;
        idex_flush_o = 1'b1;
        exmem_en_o   = 1'b1;
        memwb_en_o   = 1'b1;
        boot_cnt_nxt = boot_cnt + 4'd1;
        if (boot_cnt == 4'(BOOT_CYCLES - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // A ready in the timeout cycle still wins over the error
        if (mem_ready_i) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
          run_eval     = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if ((wait_cnt + 8'd1) == 8'(MEM_TIMEOUT)) state_nxt = ST_ERR;
        end
      end
      default: ;
    endcase

    if (run_eval) begin
      if (ex_redirect_i) begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b1;
        idex_en_o    = 1'b1;
        idex_flush_o = 1'b1;
        exmem_en_o   = 1'b1;
        memwb_en_o   = 1'b1;
        flush_evt    = 1'b1;
      end else if (load_use) begin
        idex_en_o    = 1'b1;
        idex_flush_o = 1'b1;
        exmem_en_o   = 1'b1;
        memwb_en_o   = 1'b1;
      end else begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        idex_en_o    = 1'b1;
        exmem_en_o   = 1'b1;
        memwb_en_o   = 1'b1;
      end
    end
  end

  assign stall_evt     = ((state == ST_RUN) || (state == ST_MEM_WAIT)) && !pc_en_o;
  assign mem_timeout_o = (state == ST_ERR);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_BOOT;
      boot_cnt    <= 4'd0;
      wait_cnt    <= 8'd0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_evt) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (flush_evt) flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // control vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en
  localparam logic [6:0] V_BOOT  = 7'b0011111;
  localparam logic [6:0] V_REDIR = 7'b1111111;
  localparam logic [6:0] V_LU    = 7'b0001111;
  localparam logic [6:0] V_NORM  = 7'b1101011;
  localparam logic [6:0] V_HOLD  = 7'b0000000;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0;
  logic ex_memread_i = 1'b0, ex_redirect_i = 1'b0, mem_req_i = 1'b0, mem_ready_i = 1'b0;
  logic pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o;
  logic mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i), .ex_redirect_i(ex_redirect_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_en_o(idex_en_o), .idex_flush_o(idex_flush_o),
    .exmem_en_o(exmem_en_o), .memwb_en_o(memwb_en_o),
    .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] ctl;
    logic       tmo;
    int         stalls;
    int         flushes;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // behavioural model state
  int m_booted  = 0;
  bit m_waiting = 0;
  int m_waited  = 0;
  bit m_dead    = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  function automatic bit hazard_lu(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u1, input logic u2,
                                   input logic [4:0] rd, input logic ld);
    if (!ld || rd == 5'd0) return 1'b0;
    return (u1 && rs1 == rd) || (u2 && rs2 == rd);
  endfunction

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic redir, input logic req, input logic rdy);
    exp_t e;
    bit   active;
    @(posedge clk);
    #1;
    reset_i = rst; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs1_i = u1; id_uses_rs2_i = u2;
    ex_rd_i = rd; ex_memread_i = ld; ex_redirect_i = redir; mem_req_i = req; mem_ready_i = rdy;
    cyc++;
    e.cyc = cyc;
    if (rst) begin
      m_booted = 0; m_waiting = 0; m_waited = 0; m_dead = 0; m_stalls = 0; m_flushes = 0;
      e.ctl = V_BOOT; e.tmo = 1'b0; e.stalls = 0; e.flushes = 0;
    end else begin
      e.tmo = m_dead; e.stalls = m_stalls; e.flushes = m_flushes;
      active = 1'b0;
      if (m_dead) begin
        e.ctl = V_HOLD;
      end else if (m_booted < BOOT_CYCLES) begin
        e.ctl = V_BOOT;
        m_booted++;
      end else begin
        active = 1'b1;
        if (m_waiting && !rdy) begin
          e.ctl = V_HOLD;
          m_waited++;
          if (m_waited == MEM_TIMEOUT) begin m_dead = 1; m_waiting = 0; end
        end else if (!m_waiting && req && !rdy) begin
          e.ctl = V_HOLD;
          m_waiting = 1; m_waited = 1;
        end else begin
          m_waiting = 0;
          if (redir) begin
            e.ctl = V_REDIR;
            if (m_flushes < CNT_MAX) m_flushes++;
          end else if (hazard_lu(rs1, rs2, u1, u2, rd, ld)) e.ctl = V_LU;
          else e.ctl = V_NORM;
        end
      end
      if (active && !e.ctl[6] && m_stalls < CNT_MAX) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: outputs are settled mid-cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [6:0] act, mask;
      e    = exp_q.pop_front();
      act  = {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o};
      // while ID/EX is flushed its enable has no effect
      mask = e.ctl[2] ? 7'b1110111 : 7'b1111111;
      checks++;
      if ((act & mask) !== (e.ctl & mask)) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctl);
      end
      checks++;
      if (mem_timeout_o !== e.tmo) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", e.cyc, mem_timeout_o, e.tmo);
      end
      checks++;
      if (stall_cnt_o !== CNT_W'(e.stalls)) begin
        errors++;
        $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, stall_cnt_o, e.stalls);
      end
      checks++;
      if (flush_cnt_o !== CNT_W'(e.flushes)) begin
        errors++;
        $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", e.cyc, flush_cnt_o, e.flushes);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // boot sequence then normal flow
    do_reset();
    idle(4);
    // load x5 in EX, ID reads rs2=x5: one bubble
    step(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0);
    idle(2);
    // same through rs1, and x0 destination which must not stall
    step(0, 5'd7, 5'd2, 1, 0, 5'd7, 1, 0, 0, 0);
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    step(0, 5'd3, 5'd3, 0, 0, 5'd3, 1, 0, 0, 0);
    idle(2);
    // load-use coincident with redirect
    do_reset();
    idle(2);
    step(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0);
    idle(2);
    // memory wait with redirect held throughout
    do_reset();
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // memory wait with held load-use, released by ready
    for (int i = 0; i < 2; i++) step(0, 5'd4, 0, 1, 0, 5'd4, 1, 0, 1, 0);
    step(0, 5'd4, 0, 1, 0, 5'd4, 1, 0, 1, 1);
    idle(2);
    // timeout: ready never arrives, error is sticky
    do_reset();
    idle(2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, i[0], 1, 0);
    // ready in the timeout cycle wins
    do_reset();
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    // asynchronous reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       r, u1, u2, ld, rd_, rq, rdy;
      logic [4:0] a, b, d;
      r   = ($urandom % 250) == 0;
      a   = 5'($urandom % 4);
      b   = 5'($urandom % 4);
      d   = 5'($urandom % 4);
      u1  = 1'($urandom % 2);
      u2  = 1'($urandom % 2);
      ld  = 1'($urandom % 2);
      rd_ = ($urandom % 6) == 0;
      rq  = ($urandom % 4) == 0;
      rdy = ($urandom % 3) != 0;
      step(r, a, b, u1, u2, d, ld, rd_, rq, rdy);
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expectations, exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
